// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and rising-edge count of an asynchronous PWM input.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic [7:0]       edge_cnt_o,
  output logic             level_o,
  output logic             timeout_o,
  output logic             ovf_o
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
  logic                   valid_q, valid_d, timeout_q, timeout_d, ovf_q, ovf_d;
  logic [7:0]             edge_q, edge_d;
  logic                   lvl, rise, fall;
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_i};
    lvl        = sync_q[SYNC_STAGES-1];
    rise       = lvl & ~hist_q;
    fall       = ~lvl & hist_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    ovf_d      = ovf_q;
    edge_d     = edge_q;
    if (!en_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      high_lat_d = '0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
    end else begin
      if (rise) edge_d = edge_q + 8'd1;
      if (state_q == ARM) begin
        cnt_d      = rise ? CNT_W'(1) : '0;
        high_lat_d = '0;
        state_d    = rise ? MEAS : ARM;
      end else if (rise) begin
        period_d   = cnt_q;
        high_d     = high_lat_q;
        valid_d    = 1'b1;
        cnt_d      = CNT_W'(1);
        high_lat_d = '0;
      end else if (timeout_i != '0 && cnt_q == timeout_i) begin
        timeout_d  = 1'b1;
        state_d    = ARM;
        cnt_d      = '0;
        high_lat_d = '0;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (cnt_d == CNT_MAX) ovf_d = 1'b1;
        if (fall) high_lat_d = cnt_q;
      end
    end
    // clear has priority over any edge count or flag set in the same cycle
    if (clr_i) begin
      timeout_d = 1'b0;
      ovf_d     = 1'b0;
      edge_d    = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      edge_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= lvl;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      edge_q     <= edge_d;
    end
  end
  assign period_o   = period_q;
  assign high_o     = high_q;
  assign valid_o    = valid_q;
  assign edge_cnt_o = edge_q;
  assign level_o    = lvl;
  assign timeout_o  = timeout_q;
  assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture with an 8-bit counter so saturation is reachable.
module tb_pwm_capture;
  localparam int W = 8;
  localparam int SYNC = 2;
  logic clk = 0, rst = 1, en = 0, clr = 0, pwm = 0;
  logic [W-1:0] tmo = '0;
  logic [W-1:0] period_o, high_o;
  logic valid_o, level_o, timeout_o, ovf_o;
  logic [7:0] edge_cnt_o;
  int checks = 0, failures = 0, vcount = 0, vsnap = 0, n = 0;
  pwm_capture #(.CNT_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .timeout_i(tmo), .pwm_i(pwm),
    .period_o(period_o), .high_o(high_o), .valid_o(valid_o), .edge_cnt_o(edge_cnt_o),
    .level_o(level_o), .timeout_o(timeout_o), .ovf_o(ovf_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (valid_o === 1'b1) vcount++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pwm_run(input int hi, input int lo, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      pwm = 1;
      repeat (hi) tick();
      pwm = 0;
      repeat (lo) tick();
    end
  endtask
  task automatic tmo_run(input bit stay_high);
    n = 0;
    pwm = 1;
    while (timeout_o !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 10 && !stay_high) pwm = 0;
    end
  endtask
  initial begin
    repeat (3) begin
      tick();
      pwm = ~pwm;
    end
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_edge", edge_cnt_o, 0);
    check("rst_level", level_o, 0);
    check("rst_flags", {timeout_o, ovf_o}, 0);
    check("rst_nopulse", vcount, 0);
    rst = 0; en = 1; pwm = 0;
    repeat (5) tick();
    pwm_run(25, 75, 5);
    check("steady_nvalid", vcount, 4);
    check("steady_period", period_o, 100);
    check("steady_high", high_o, 25);
    check("steady_edge", edge_cnt_o, 5);
    pwm = 1;
    for (int i = 0; i <= SYNC; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("lat_valid", valid_o, (i == SYNC) ? 1 : 0);
    end
    check("lat_period", period_o, 100);
    check("lat_edge", edge_cnt_o, 6);
    tick();
    pwm = 0; en = 0;
    repeat (2) tick();
    en = 1;
    repeat (5) tick();
    tmo = 50;
    vsnap = vcount;
    tmo_run(0);
    check("tmo_lat", n, SYNC + 51);
    check("tmo_flag", timeout_o, 1);
    check("tmo_level", level_o, 0);
    check("tmo_period", period_o, 100);
    check("tmo_high", high_o, 25);
    check("tmo_novalid", vcount, vsnap);
    check("tmo_edge", edge_cnt_o, 7);
    clr = 1; tick(); clr = 0;
    check("clr_tmo", timeout_o, 0);
    check("clr_edge", edge_cnt_o, 0);
    tmo_run(1);
    check("tmoh_lat", n, SYNC + 51);
    check("tmoh_level", level_o, 1);
    check("tmoh_novalid", vcount, vsnap);
    check("tmoh_edge", edge_cnt_o, 1);
    tmo = 0;
    pwm = 0;
    repeat (5) tick();
    pwm_run(100, 200, 1);
    check("ovf_novalid", vcount, vsnap);
    check("ovf_flag_early", ovf_o, 1);
    n = 0;
    pwm = 1;
    while (valid_o !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("ovf_wait", n, SYNC + 1);
    check("ovf_period", period_o, 255);
    check("ovf_high", high_o, 100);
    check("ovf_flag", ovf_o, 1);
    check("ovf_edge", edge_cnt_o, 3);
    pwm = 0;
    repeat (30) tick();
    pwm_run(10, 30, 4);
    check("pre_edge", edge_cnt_o, 7);
    check("pre_flags", {timeout_o, ovf_o}, 3);
    pwm = 1;
    repeat (2) tick();
    clr = 1; tick(); clr = 0;
    check("coin_valid", valid_o, 1);
    check("coin_period", period_o, 40);
    check("coin_high", high_o, 10);
    check("coin_edge", edge_cnt_o, 0);
    check("coin_flags", {timeout_o, ovf_o}, 0);
    repeat (5) tick();
    en = 0;
    vsnap = vcount;
    repeat (3) tick();
    check("dis_novalid", vcount, vsnap);
    en = 1; pwm = 0;
    repeat (20) tick();
    pwm_run(10, 30, 3);
    check("reen_nvalid", vcount - vsnap, 2);
    check("reen_period", period_o, 40);
    check("reen_high", high_o, 10);
    clr = 1; tick(); clr = 0;
    pwm_run(2, 2, 255);
    repeat (3) tick();
    check("wrap_255", edge_cnt_o, 255);
    check("wrap_period", period_o, 4);
    check("wrap_high", high_o, 2);
    pwm_run(2, 2, 1);
    check("wrap_0", edge_cnt_o, 0);
    pwm_run(10, 30, 1);
    pwm = 1;
    repeat (2) tick();
    vsnap = vcount;
    rst = 1;
    tick();
    check("mrst_valid", valid_o, 0);
    check("mrst_period", period_o, 0);
    check("mrst_edge", edge_cnt_o, 0);
    tick();
    check("mrst_novalid", vcount, vsnap);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Synthesizable PWM input-capture unit that measures the period, high time and rising-edge count of an external PWM waveform entering through a user-project GPIO. It is the receiving end of the PWM output path. It lets firmware on the Ibex core check its own PWM output in loopback, or measure an external PWM source. The block sits behind the peripheral register interface; the register wrapper consumes its outputs.

Parameters:
CNT_W, 16, width of the period/high-time counters and of timeout_i.
SYNC_STAGES, 2, number of flops in the pwm_i synchronizer (minimum 2).

Ports:
clk_i  input  1  system clock.
rst_i  input  1  synchronous, active-high reset.
en_i  input  1  capture enable; low forces IDLE.
clr_i  input  1  one-cycle pulse; clears sticky flags and edge_cnt_o.
timeout_i  input  CNT_W  cycles without a rising edge before timeout; 0 disables timeout.
pwm_i  input  1  asynchronous PWM input.
period_o  output  CNT_W  last measured period, in clk_i cycles.
high_o  output  CNT_W  last measured high time, in clk_i cycles.
valid_o  output  1  one-cycle pulse when period_o/high_o update.
edge_cnt_o  output  8  rising edges seen while enabled; wraps 255->0.
level_o  output  1  synchronized pwm_i level.
timeout_o  output  1  sticky; no rising edge within timeout_i cycles.
ovf_o  output  1  sticky; counter saturated.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): state=IDLE; all outputs 0; cnt, high_lat and synchronizer flops 0.
- Synchronizer: SYNC_STAGES flops followed by one history flop. rise = sync & ~hist; fall = ~sync & hist. level_o = sync.
- Latency: valid_o and edge_cnt_o update exactly SYNC_STAGES clocks after the clk_i edge that first samples pwm_i high.
- FSM IDLE: entered whenever en_i=0, from any state. Counters are held at 0. period_o and high_o hold their last values. Move to ARM when en_i=1.
- FSM ARM: wait for rise. On rise: cnt<=1, go to MEAS, edge_cnt_o increments, no valid_o. The first partial period is always discarded.
- FSM MEAS, counter: cnt increments by 1 each cycle and saturates at all-ones. Reaching all-ones sets ovf_o.
- FSM MEAS, on fall: high_lat<=cnt.
- FSM MEAS, on rise: period_o<=cnt, high_o<=high_lat, valid_o=1 for one cycle, cnt<=1, high_lat<=0, edge_cnt_o++.
- FSM MEAS, timeout: if timeout_i!=0 and cnt==timeout_i with no rise in that cycle, set timeout_o, go to ARM, and leave period_o/high_o unchanged. Firmware reads level_o to distinguish 0% from 100% duty.
- Resulting values: for a waveform with P cycles between rising edges and H cycles high, period_o=P and high_o=H.
- A period with no falling edge cannot occur with rises on a single-bit input. Hence high_o<period_o is always true unless cnt saturated.
- If cnt saturated during a period, the rise still produces valid_o, with period_o=all-ones; ovf_o stays set.
- clr_i clears timeout_o, ovf_o and edge_cnt_o. If clr_i coincides with rise, clr wins: edge_cnt_o=0 and the rise is not counted, but measurement proceeds normally. If clr_i coincides with a flag-setting event, the flag ends up 0.
- en_i falling mid-period: next cycle is IDLE and the partial measurement is dropped without valid_o. Re-enable restarts in ARM.
- rst_i mid-operation: immediate return to the reset state on that clock edge; no valid_o.

Test Plan:
- Reset: hold rst_i 3 cycles with pwm_i toggling -> all outputs 0, valid_o never pulses.
- Steady PWM, en_i=1: period 100 cycles, high 25, 5 rising edges. Expect no valid_o on the 1st edge; 4 valid_o pulses, each with period_o=100, high_o=25; edge_cnt_o=5. Check valid_o arrives SYNC_STAGES clocks after the sampling edge.
- Timeout: timeout_i=50, stop pwm_i low after one rise. Expect timeout_o=1 at cnt==50, state ARM, level_o=0, period_o unchanged. Repeat with pwm_i stuck high -> level_o=1.
- Overflow: CNT_W=8, period 300 cycles. Expect ovf_o=1 and period_o=255 on the next valid_o.
- clr_i coinciding with a rise after edge_cnt_o=7: expect edge_cnt_o=0, timeout_o/ovf_o=0, and valid_o still pulses with the correct period.
- Disable mid-period then re-enable with period 40/high 10: expect no valid_o for the dropped period; the first valid after re-arm shows 40/10. Also check 256 edges wrap edge_cnt_o to 0.
